// File: rtl/spi_agg_pkg.sv
// spi_agg_pkg: constants and types shared by the ADC aggregator transmitter
// and the SPI frame receiver.
//   NUM_CH         channels per frame
//   CH_W           width of one right-justified channel word
//   MAX_FRAME_BITS longest valid frame (NUM_CH * CH_W)
//   BITCNT_W       frame bit counter width (saturates at 2**BITCNT_W-1)
package spi_agg_pkg;

  localparam int NUM_CH         = 4;
  localparam int CH_W           = 16;
  localparam int MAX_FRAME_BITS = 64;
  localparam int BITCNT_W       = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/spi_rx_sync.sv
// spi_rx_sync: brings the asynchronous SPI pins into the clk domain.
//   clk, rst_n          receiver clock, async active-low reset
//   spi_sclk/cs_n/mosi  raw link pins
//   sclk_rise/sclk_fall single-cycle edge strobes on the synced sclk
//   cs_rise/cs_fall     single-cycle edge strobes on the synced cs_n
//   mosi_aligned        mosi delayed by the same depth as sclk, so it is valid
//                       in the cycle an sclk edge strobe fires
module spi_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic mosi_aligned
);

  logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
  logic                   sclk_hist, cs_hist;

  // The cs_n chain resets to 0 rather than the idle-high level. A cs_n that is
  // already low when reset releases then never shows a falling edge, so a
  // frame in progress is not captured; the spurious rise seen when cs_n is
  // idle high is harmless because the FSM ignores rises in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr   <= '0;
      cs_sr     <= '0;
      mosi_sr   <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      sclk_hist <= sclk_sr[SYNC_STAGES-1];
      cs_hist   <= cs_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_rise    =  sclk_sr[SYNC_STAGES-1] & ~sclk_hist;
  assign sclk_fall    = ~sclk_sr[SYNC_STAGES-1] &  sclk_hist;
  assign cs_rise      =  cs_sr[SYNC_STAGES-1]   & ~cs_hist;
  assign cs_fall      = ~cs_sr[SYNC_STAGES-1]   &  cs_hist;
  assign mosi_aligned =  mosi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: SPI-slave deserializer for the 4-channel aggregator frame.
// Oversamples cs_n/sclk/mosi on clk, recovers four N-bit words (MSB first,
// channel 0 first) and presents them on a valid/ready interface.
//   clk, rst_n          receiver clock (>= 4x sclk), async active-low reset
//   cfg_adc_bits_m1     bits per channel minus 1, latched at frame start
//   spi_sclk/cs_n/mosi  link pins, asynchronous to clk
//   ch0..ch3_data       received words, right-justified
//   out_valid/out_ready frame handshake
//   frame_err           pulse: frame length was not 4N bits
//   overrun             pulse: good frame dropped, previous one still held
//   busy                frame in progress
// Build option: define SPI_RX_SIGN_EXT_EN to sign-extend each word from bit
// N-1; otherwise the upper 16-N bits are zero.
//
// state | meaning
// IDLE  | waiting for cs_n to fall; sclk edges ignored
// RECV  | shifting sample-edge bits into the channel registers
module spi_frame_receiver
  import spi_agg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_FALLING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cfg_adc_bits_m1,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic [15:0] ch0_data,
  output logic [15:0] ch1_data,
  output logic [15:0] ch2_data,
  output logic [15:0] ch3_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_aligned, sample;

  spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .sclk_rise    (sclk_rise),
    .sclk_fall    (sclk_fall),
    .cs_rise      (cs_rise),
    .cs_fall      (cs_fall),
    .mosi_aligned (mosi_aligned)
  );

  assign sample = (SAMPLE_FALLING != 0) ? sclk_fall : sclk_rise;

  rx_state_e                        state_q, state_d;
  logic [4:0]                       n_q;
  logic [BITCNT_W-1:0]              bit_cnt_q, bit_cnt_d;
  logic [NUM_CH-1:0][CH_W-1:0]      sh_q, sh_d;
  logic [BITCNT_W-1:0]              n1, n2, n3, n4;
  logic [1:0]                       sel;
  logic                             start, load, err, ovr;

  function automatic logic [CH_W-1:0] fit_word(input logic [CH_W-1:0] w,
                                               input logic [4:0] n);
`ifdef SPI_RX_SIGN_EXT_EN
    logic [CH_W-1:0] r;
    logic [3:0]      msb;
    r   = w;
    msb = 4'(n - 5'd1);
    for (int i = 0; i < CH_W; i++)
      if (i >= int'(n)) r[i] = w[msb];
    return r;
`else
    // Only N bits ever reach a channel register, so the mask is a no-op in
    // practice; it keeps the word strictly N bits wide by construction.
    return w & (16'hFFFF >> (5'd16 - n));
`endif
  endfunction

  // Channel boundaries at N, 2N, 3N, 4N replace a divide of bit_cnt by N.
  assign n1 = {2'b00, n_q};
  assign n2 = n1 << 1;
  assign n3 = n1 + n2;
  assign n4 = n1 << 2;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    start     = 1'b0;
    load      = 1'b0;
    err       = 1'b0;
    ovr       = 1'b0;
    if (bit_cnt_q >= n3)      sel = 2'd3;
    else if (bit_cnt_q >= n2) sel = 2'd2;
    else if (bit_cnt_q >= n1) sel = 2'd1;
    else                      sel = 2'd0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = RECV;
          start   = 1'b1;
        end
      end
      RECV: begin
        if (sample) begin
          if (bit_cnt_q < n4)
            sh_d[sel] = {sh_q[sel][CH_W-2:0], mosi_aligned};
          if (bit_cnt_q != '1)
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
        // Evaluated on the post-edge count/shift so a final sample edge in the
        // same synced cycle as the cs_n rise is included.
        if (cs_rise) begin
          state_d = IDLE;
          if (bit_cnt_d == n4) begin
            if (!out_valid || out_ready) load = 1'b1;
            else                         ovr  = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      ch0_data  <= '0;
      ch1_data  <= '0;
      ch2_data  <= '0;
      ch3_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= err;
      overrun   <= ovr;
      if (start) begin
        n_q       <= {1'b0, cfg_adc_bits_m1} + 5'd1;
        bit_cnt_q <= '0;
        sh_q      <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_d;
        sh_q      <= sh_d;
      end
      if (load) begin
        ch0_data  <= fit_word(sh_d[0], n_q);
        ch1_data  <= fit_word(sh_d[1], n_q);
        ch2_data  <= fit_word(sh_d[2], n_q);
        ch3_data  <= fit_word(sh_d[3], n_q);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q == RECV);

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver: directed and randomized frames for spi_frame_receiver.
// Expected words come from the transmitted words masked (or sign-extended
// when SPI_RX_SIGN_EXT_EN is defined) to N bits; a frame is good iff exactly
// 4N sample edges occur while cs_n is low.
module tb_spi_frame_receiver;

  localparam int SYNC = 2;

  logic        clk, rst_n;
  logic [3:0]  cfg_adc_bits_m1;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic [15:0] ch0_data, ch1_data, ch2_data, ch3_data;
  logic        out_valid, out_ready, frame_err, overrun, busy;

  spi_frame_receiver #(.SYNC_STAGES(SYNC), .SAMPLE_FALLING(1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_adc_bits_m1 (cfg_adc_bits_m1),
    .spi_sclk        (spi_sclk),
    .spi_cs_n        (spi_cs_n),
    .spi_mosi        (spi_mosi),
    .ch0_data        (ch0_data),
    .ch1_data        (ch1_data),
    .ch2_data        (ch2_data),
    .ch3_data        (ch3_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .frame_err       (frame_err),
    .overrun         (overrun),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          n_err    = 0;
  int          n_ovr    = 0;
  logic [63:0] got_q[$];
  logic [15:0] tx_w[4];

  // Record accepted frames and error/overrun pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready)
        got_q.push_back({ch3_data, ch2_data, ch1_data, ch0_data});
      if (frame_err) n_err++;
      if (overrun)   n_ovr++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] w, input int n);
    logic [15:0] mask, v;
    mask = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
    v    = w & mask;
`ifdef SPI_RX_SIGN_EXT_EN
    if (v[n-1]) v = v | ~mask;
`endif
    return v;
  endfunction

  function automatic logic [63:0] exp_frame(input int n);
    return {exp_word(tx_w[3], n), exp_word(tx_w[2], n),
            exp_word(tx_w[1], n), exp_word(tx_w[0], n)};
  endfunction

  // Drives one frame: data changes on sclk rise, receiver samples on fall.
  // cfg is scrambled after the first bit to show it is latched at frame start.
  task automatic send(input int n, input int nbits, input bit raise, input bit coincide);
    logic b;
    int   ch, idx;
    cfg_adc_bits_m1 = 4'(n - 1);
    spi_cs_n = 1'b0;
    #40;
    for (int k = 0; k < nbits; k++) begin
      if (k < 4 * n) begin
        ch  = k / n;
        idx = n - 1 - (k % n);
        b   = tx_w[ch][idx];
      end else begin
        b = 1'($urandom);
      end
      spi_sclk = 1'b1;
      spi_mosi = b;
      #40;
      if (coincide && k == nbits - 1) begin
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
      end else begin
        spi_sclk = 1'b0;
        #40;
      end
      if (k == 0) cfg_adc_bits_m1 = 4'($urandom);
    end
    if (raise && !coincide) spi_cs_n = 1'b1;
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  int          e0, o0, lat, n, nbits, good;
  logic [63:0] a_frame;

  initial begin
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    cfg_adc_bits_m1 = 4'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_err",   64'(frame_err), 64'd0);
    check("rst_ovr",   64'(overrun),   64'd0);
    check("rst_data",  {ch3_data, ch2_data, ch1_data, ch0_data}, 64'd0);
    rst_n = 1'b1;
    settle();

    // N=12 known frame, latency, busy
    tx_w[0] = 16'hABC; tx_w[1] = 16'h123; tx_w[2] = 16'h456; tx_w[3] = 16'h789;
    got_q.delete(); e0 = n_err;
    send(12, 48, 0, 0);
    #10;
    check("n12_busy", 64'(busy), 64'd1);
    spi_cs_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      #10;
      if (out_valid) lat = i;
    end
    check("n12_latency_ok", 64'(lat >= SYNC + 1 && lat <= SYNC + 3), 64'd1);
    settle();
    check("n12_count", 64'(got_q.size()), 64'd1);
`ifdef SPI_RX_SIGN_EXT_EN
    if (got_q.size() > 0) check("n12_data", got_q[0], 64'h0789_0456_0123_FABC);
`else
    if (got_q.size() > 0) check("n12_data", got_q[0], 64'h0789_0456_0123_0ABC);
`endif
    check("n12_noerr", 64'(n_err - e0), 64'd0);
    check("n12_idle", 64'(busy), 64'd0);

    // N=16, two back-to-back frames, second ends with sclk fall on cs_n rise
    tx_w[0] = 16'hFFFF; tx_w[1] = 16'h0000; tx_w[2] = 16'h8001; tx_w[3] = 16'h7FFE;
    got_q.delete(); e0 = n_err;
    send(16, 64, 1, 0);
    #20;
    send(16, 64, 1, 1);
    settle();
    check("n16_count", 64'(got_q.size()), 64'd2);
    for (int i = 0; i < got_q.size(); i++)
      check("n16_data", got_q[i], 64'h7FFE_8001_0000_FFFF);
    check("n16_noerr", 64'(n_err - e0), 64'd0);

    // Wrong lengths
    tx_w[0] = 16'hABC; tx_w[1] = 16'h123; tx_w[2] = 16'h456; tx_w[3] = 16'h789;
    got_q.delete(); e0 = n_err;
    send(12, 47, 1, 0);
    settle();
    check("short_err", 64'(n_err - e0), 64'd1);
    check("short_novalid", 64'(out_valid), 64'd0);
    send(12, 49, 1, 0);
    settle();
    check("long_err", 64'(n_err - e0), 64'd2);
    check("len_nocount", 64'(got_q.size()), 64'd0);

    // Overrun with out_ready low
    out_ready = 1'b0;
    got_q.delete(); e0 = n_err; o0 = n_ovr;
    tx_w[0] = 16'h1; tx_w[1] = 16'h2; tx_w[2] = 16'h3; tx_w[3] = 16'h4;
    send(4, 16, 1, 0);
    settle();
    check("ovr_valid", 64'(out_valid), 64'd1);
    check("ovr_first", {ch3_data, ch2_data, ch1_data, ch0_data}, 64'h0004_0003_0002_0001);
    tx_w[0] = 16'h5; tx_w[1] = 16'h6; tx_w[2] = 16'h7; tx_w[3] = 16'h8;
    send(4, 16, 1, 0);
    settle();
    check("ovr_pulse", 64'(n_ovr - o0), 64'd1);
    check("ovr_hold", {ch3_data, ch2_data, ch1_data, ch0_data}, 64'h0004_0003_0002_0001);
    check("ovr_noerr", 64'(n_err - e0), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    settle();
    check("ovr_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("ovr_accept", got_q[0], 64'h0004_0003_0002_0001);
    check("ovr_drop", 64'(out_valid), 64'd0);

    // Reset in mid-frame
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tx_w[i] = 16'($urandom);
    send(12, 48, 1, 0);
    settle();
    check("prerst_valid", 64'(out_valid), 64'd1);
    send(12, 20, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy",  64'(busy), 64'd0);
    check("midrst_data",  {ch3_data, ch2_data, ch1_data, ch0_data}, 64'd0);
    #29 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("orphan_busy", 64'(busy), 64'd0);
    spi_cs_n = 1'b1;
    out_ready = 1'b1;
    settle();
    got_q.delete(); e0 = n_err;
    for (int i = 0; i < 4; i++) tx_w[i] = 16'($urandom);
    send(12, 48, 1, 0);
    settle();
    check("fresh_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("fresh_data", got_q[0], exp_frame(12));
    check("fresh_noerr", 64'(n_err - e0), 64'd0);

    // Randomized frames
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < 4; i++) tx_w[i] = 16'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    nbits = 4 * n;
        2:       nbits = 4 * n - 1;
        default: nbits = 4 * n + 2;
      endcase
      good = (nbits == 4 * n);
      got_q.delete(); e0 = n_err;
      send(n, nbits, 1, 1'($urandom_range(0, 1)));
      settle();
      if (good != 0) begin
        check("rnd_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check("rnd_data", got_q[0], exp_frame(n));
        check("rnd_noerr", 64'(n_err - e0), 64'd0);
      end else begin
        check("rnd_badcount", 64'(got_q.size()), 64'd0);
        check("rnd_err", 64'(n_err - e0), 64'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
